grid_move_scheduler: RTL and testbench

Shares one grid-walker position datapath (5-bit add/subtract with clamping to 0..15) among NREQ requesters. Each requester submits move commands (direction, steps) over a valid/ready handshake. A round-robin arbiter accepts one command at a time. A two-state FSM drives the shared `five_bit_as` unit and commits the clamped X/Y position. The block sits between the command sources and the position consumers, replacing direct per-clock driving of the walker.

---
 rtl/grid_pkg.sv | 25 ++
 rtl/five_bit_as.sv | 28 ++
 rtl/grid_move_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_grid_move_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grid_pkg
//  Description : Shared types and constants for the grid move scheduler:
//                direction codes, coordinate width, default clamp limit and
//                the scheduler FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package grid_pkg;

    localparam int POS_W        = 5;
    localparam int GRID_MAX_DEF = 15;

    localparam logic [1:0] DIR_EAST  = 2'b00;
    localparam logic [1:0] DIR_WEST  = 2'b01;
    localparam logic [1:0] DIR_NORTH = 2'b10;
    localparam logic [1:0] DIR_SOUTH = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage : grid_pkg
`default_nettype wire

// File: rtl/five_bit_as.sv
`default_nettype none
// ============================================================================
//  Module      : five_bit_as
//  Description : 5-bit adder/subtractor. opcode 0 adds, opcode 1 subtracts
//                (a + ~b + 1). carry is the raw carry out, over is the
//                two's-complement overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module five_bit_as (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       opcode,
    output logic [4:0] out,
    output logic       carry,
    output logic       over
);

    logic [4:0] w_b;

    // Invert b for subtraction and feed opcode in as the carry-in
    always_comb begin
        w_b          = opcode ? ~b : b;
        {carry, out} = {1'b0, a} + {1'b0, w_b} + {5'b0_0000, opcode};
        over         = (a[4] == w_b[4]) && (out[4] != a[4]);
    end

endmodule : five_bit_as
`default_nettype wire

// File: rtl/grid_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : grid_move_scheduler
//  Description : Round-robin arbitration of move commands from NREQ
//                requesters onto one shared add/subtract unit that updates a
//                clamped X/Y grid position. One move per two cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module grid_move_scheduler
    import grid_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int GRID_MAX = GRID_MAX_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [2*NREQ-1:0]       req_dir,
    input  logic [2*NREQ-1:0]       req_steps,
    output logic [NREQ-1:0]         req_ready,
    output logic                    resp_valid,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic                    resp_sat,
    output logic [POS_W-1:0]        outx,
    output logic [POS_W-1:0]        outy,
    output logic                    busy
);

    localparam int                ID_W       = $clog2(NREQ);
    localparam logic [POS_W-1:0]  C_GRID_MAX = POS_W'(GRID_MAX);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]         op_dir_q, op_dir_d;
    logic [1:0]         op_steps_q, op_steps_d;
    logic [ID_W-1:0]    op_id_q, op_id_d;
    logic [POS_W-1:0]   outx_q, outx_d;
    logic [POS_W-1:0]   outy_q, outy_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic               resp_sat_q, resp_sat_d;

    logic               w_found;
    logic [ID_W-1:0]    w_grant;
    logic [ID_W-1:0]    w_rr_next;
    logic [1:0]         w_sel_dir;
    logic [1:0]         w_sel_steps;
    logic               w_axis_y;
    logic               w_opc;
    logic [POS_W-1:0]   w_a;
    logic [POS_W-1:0]   w_b;
    logic [POS_W-1:0]   w_sum;
    logic               w_carry;
    logic               w_over;
    logic [POS_W-1:0]   w_clamped;
    logic               w_sat;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    // Scanning from the far end lets the closest candidate win last.
    always_comb begin
        int idx;
        int nxt;
        idx       = 0;
        nxt       = 0;
        w_found   = 1'b0;
        w_grant   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_valid[ID_W'(idx)]) begin
                w_found = 1'b1;
                w_grant = ID_W'(idx);
            end
        end
        nxt = int'(w_grant) + 1;
        if (nxt >= NREQ) begin
            nxt = 0;
        end
        w_rr_next = ID_W'(nxt);
    end

    // Pick the granted requester's command fields
    always_comb begin
        w_sel_dir   = 2'b00;
        w_sel_steps = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == w_grant) begin
                w_sel_dir   = req_dir[2*i +: 2];
                w_sel_steps = req_steps[2*i +: 2];
            end
        end
    end

    // One-hot accept, only in IDLE and never while reset is asserted
    always_comb begin
        req_ready = '0;
        if (!rst && (state_q == ST_IDLE) && w_found) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    // Shared datapath operands come only from the latched op, never the ports
    always_comb begin
        w_axis_y = (op_dir_q == DIR_NORTH) || (op_dir_q == DIR_SOUTH);
        w_opc    = (op_dir_q == DIR_WEST)  || (op_dir_q == DIR_SOUTH);
        w_a      = w_axis_y ? outy_q : outx_q;
        w_b      = {{(POS_W-2){1'b0}}, op_steps_q};
    end

    five_bit_as u_as (
        .a      (w_a),
        .b      (w_b),
        .opcode (w_opc),
        .out    (w_sum),
        .carry  (w_carry),
        .over   (w_over)
    );

    // Clamp: adds saturate at GRID_MAX, subtracts that go negative stop at 0
    always_comb begin
        w_clamped = w_sum;
        w_sat     = 1'b0;
        if (!w_opc) begin
            if (w_carry || (w_sum > C_GRID_MAX)) begin
                w_clamped = C_GRID_MAX;
                w_sat     = 1'b1;
            end
        end else if (w_sum[POS_W-1] ^ w_over) begin
            w_clamped = '0;
            w_sat     = 1'b1;
        end
    end

    // FSM next-state and registered-output next values
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_dir_d     = op_dir_q;
        op_steps_d   = op_steps_q;
        op_id_d      = op_id_q;
        outx_d       = outx_q;
        outy_d       = outy_q;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_sat_d   = resp_sat_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    op_dir_d   = w_sel_dir;
                    op_steps_d = w_sel_steps;
                    op_id_d    = w_grant;
                    rr_ptr_d   = w_rr_next;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_axis_y) begin
                    outy_d = w_clamped;
                end else begin
                    outx_d = w_clamped;
                end
                resp_valid_d = 1'b1;
                resp_id_d    = op_id_q;
                resp_sat_d   = w_sat;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            op_dir_q     <= 2'b00;
            op_steps_q   <= 2'b00;
            op_id_q      <= '0;
            outx_q       <= '0;
            outy_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sat_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_dir_q     <= op_dir_d;
            op_steps_q   <= op_steps_d;
            op_id_q      <= op_id_d;
            outx_q       <= outx_d;
            outy_q       <= outy_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sat_q   <= resp_sat_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sat   = resp_sat_q;
    assign outx       = outx_q;
    assign outy       = outy_q;
    assign busy       = (state_q == ST_EXEC);

endmodule : grid_move_scheduler
`default_nettype wire

// File: tb/tb_grid_move_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grid_move_scheduler
//  Description : Scoreboard bench for grid_move_scheduler (NREQ=2). Stimulus
//                pushes hand-computed responses; a negedge monitor pops and
//                compares whenever resp_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grid_move_scheduler;
    import grid_pkg::*;

    localparam int NREQ = 2;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [2*NREQ-1:0] req_dir;
    logic [2*NREQ-1:0] req_steps;
    logic [NREQ-1:0]  req_ready;
    logic             resp_valid;
    logic [0:0]       resp_id;
    logic             resp_sat;
    logic [4:0]       outx;
    logic [4:0]       outy;
    logic             busy;

    typedef struct {
        int id;
        int sat;
        int x;
        int y;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    grid_move_scheduler #(
        .NREQ     (NREQ),
        .GRID_MAX (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_dir    (req_dir),
        .req_steps  (req_steps),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_sat   (resp_sat),
        .outx       (outx),
        .outy       (outy),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: every resp_valid cycle must match the oldest expectation
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_id",  32'(resp_id),  32'(e.id));
                chk("resp_sat", 32'(resp_sat), 32'(e.sat));
                chk("outx",     32'(outx),     32'(e.x));
                chk("outy",     32'(outy),     32'(e.y));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one move from requester id, starting 1 time unit after a posedge
    task automatic do_move(int id, logic [1:0] d, logic [1:0] s, int ex, int ey, int esat);
        exp_t e;
        req_valid           = '0;
        req_valid[id]       = 1'b1;
        req_dir[2*id +: 2]  = d;
        req_steps[2*id +: 2] = s;
        @(negedge clk);
        chk("accept_ready", 32'(req_ready), 32'(1 << id));
        e.id = id; e.sat = esat; e.x = ex; e.y = ey;
        q.push_back(e);
        step();
        req_valid = '0;
        req_dir   = ~req_dir;
        req_steps = ~req_steps;
        @(negedge clk);
        chk("exec_busy",  32'(busy),      32'd1);
        chk("exec_ready", 32'(req_ready), 32'd0);
        step();
    endtask

    // Two-cycle reset with both requesters asserting valid
    task automatic rst_seq();
        rst       = 1'b1;
        req_valid = '1;
        req_dir   = '0;
        req_steps = '1;
        for (int c = 0; c < 2; c++) begin
            step();
            @(negedge clk);
            chk("rst_ready",      32'(req_ready),  32'd0);
            chk("rst_busy",       32'(busy),       32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_outx",       32'(outx),       32'd0);
            chk("rst_outy",       32'(outy),       32'd0);
        end
        rst       = 1'b0;
        req_valid = '0;
        step();
    endtask

    initial begin
        exp_t e;
        rst       = 1'b1;
        req_valid = '0;
        req_dir   = '0;
        req_steps = '0;
        rst_seq();
        chk("rst_resp_id",  32'(resp_id),  32'd0);
        chk("rst_resp_sat", 32'(resp_sat), 32'd0);

        // East walk up to the clamp
        do_move(0, DIR_EAST, 2'd3,  3, 0, 0);
        do_move(0, DIR_EAST, 2'd3,  6, 0, 0);
        do_move(0, DIR_EAST, 2'd3,  9, 0, 0);
        do_move(0, DIR_EAST, 2'd3, 12, 0, 0);
        do_move(0, DIR_EAST, 2'd2, 14, 0, 0);
        do_move(1, DIR_EAST, 2'd3, 15, 0, 1);
        // West walk down to the clamp
        do_move(0, DIR_WEST, 2'd3, 12, 0, 0);
        do_move(0, DIR_WEST, 2'd3,  9, 0, 0);
        do_move(0, DIR_WEST, 2'd3,  6, 0, 0);
        do_move(0, DIR_WEST, 2'd3,  3, 0, 0);
        do_move(0, DIR_WEST, 2'd1,  2, 0, 0);
        do_move(1, DIR_WEST, 2'd3,  0, 0, 1);
        // Y axis, zero steps, south clamp
        do_move(0, DIR_NORTH, 2'd3, 0, 3, 0);
        do_move(0, DIR_NORTH, 2'd3, 0, 6, 0);
        do_move(0, DIR_NORTH, 2'd1, 0, 7, 0);
        do_move(1, DIR_NORTH, 2'd0, 0, 7, 0);
        do_move(0, DIR_SOUTH, 2'd3, 0, 4, 0);
        do_move(0, DIR_SOUTH, 2'd3, 0, 1, 0);
        do_move(1, DIR_SOUTH, 2'd3, 0, 0, 1);

        // Round-robin: both hold north 1, grants alternate 0,1,0,1
        rst_seq();
        req_valid = 2'b11;
        req_dir   = {DIR_NORTH, DIR_NORTH};
        req_steps = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 2)));
            e.id = k % 2; e.sat = 0; e.x = 0; e.y = k + 1;
            q.push_back(e);
            step();
            @(negedge clk);
            chk("rr_exec_ready", 32'(req_ready), 32'd0);
            if (k == 3) begin
                req_valid = '0;
            end
            step();
        end
        step();

        // Reset while EXEC: command discarded, pointer back to requester 0
        do_move(0, DIR_EAST, 2'd3, 3, 4, 0);
        do_move(1, DIR_EAST, 2'd2, 5, 4, 0);
        req_valid    = 2'b01;
        req_dir      = {DIR_EAST, DIR_WEST};
        req_steps    = 4'b0010;
        @(negedge clk);
        chk("abort_accept", 32'(req_ready), 32'd1);
        step();
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_outx",       32'(outx),       32'd0);
        chk("abort_outy",       32'(outy),       32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_busy_clr",   32'(busy),       32'd0);
        req_valid = 2'b11;
        req_dir   = {DIR_NORTH, DIR_NORTH};
        req_steps = 4'b0101;
        #1;
        chk("abort_rr_restart", 32'(req_ready), 32'd1);
        e.id = 0; e.sat = 0; e.x = 0; e.y = 1;
        q.push_back(e);
        step();
        req_valid = '0;
        step();
        step();
        step();

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_grid_move_scheduler
`default_nettype wire
